// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID decode/redirect inputs and stall/flush/forward controls of hazard_ctrl
interface hazard_ctrl_if;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] id_rd;
    logic       id_regwr;
    logic       id_load;
    logic       m_pcsrc;
    logic       stall;
    logic       flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_regwr, id_load, m_pcsrc,
        input  stall, flush, fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_regwr, id_load, m_pcsrc,
        output stall, flush, fwd_a, fwd_b
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - scoreboard-based stall/flush/forward controller for the 5-stage core
// HAZARD_FWD_EN: compile in the forwarding network (load-use-only stalls, live fwd_a/fwd_b)
module hazard_ctrl #(
    parameter int SAT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    hazard_ctrl_if.slave     hz,
    output logic [SAT_W-1:0] stall_count,
    output logic [SAT_W-1:0] flush_count
);
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       load;
    } slot_t;

    slot_t sb_ex, sb_m, sb_wb;
    logic  issue;
    logic  stall_raw;
    logic  ex_hit;
    logic  m_hit;

    function automatic logic src_match(input slot_t s, input logic used, input logic [4:0] addr);
        return used && (addr != 5'd0) && s.valid && (s.rd == addr);
    endfunction

    assign ex_hit = src_match(sb_ex, hz.id_rs1_used, hz.id_rs1)
                  | src_match(sb_ex, hz.id_rs2_used, hz.id_rs2);
    assign m_hit  = src_match(sb_m, hz.id_rs1_used, hz.id_rs1)
                  | src_match(sb_m, hz.id_rs2_used, hz.id_rs2);

`ifdef HAZARD_FWD_EN
    logic [4:0] ex_rs1, ex_rs2;
    logic       ex_rs1_used, ex_rs2_used;

    // M wins over WB; a load still in M has no data yet, so it cannot be the source
    function automatic logic [1:0] fwd_sel(input slot_t m_slot, input slot_t wb_slot,
                                           input logic used, input logic [4:0] addr);
        if (src_match(m_slot, used, addr) && !m_slot.load) return 2'b01;
        if (src_match(wb_slot, used, addr))                return 2'b10;
        return 2'b00;
    endfunction

    assign stall_raw = ex_hit & sb_ex.load;
    assign hz.fwd_a  = clr ? 2'b00 : fwd_sel(sb_m, sb_wb, ex_rs1_used, ex_rs1);
    assign hz.fwd_b  = clr ? 2'b00 : fwd_sel(sb_m, sb_wb, ex_rs2_used, ex_rs2);

    wire unused_fwd = m_hit ^ sb_wb.load;

    always_ff @(negedge clk) begin
        if (clr) begin
            ex_rs1      <= 5'd0;
            ex_rs2      <= 5'd0;
            ex_rs1_used <= 1'b0;
            ex_rs2_used <= 1'b0;
        end else begin
            ex_rs1      <= hz.id_rs1;
            ex_rs2      <= hz.id_rs2;
            ex_rs1_used <= issue & hz.id_rs1_used;
            ex_rs2_used <= issue & hz.id_rs2_used;
        end
    end
`else
    assign stall_raw = ex_hit | m_hit;
    assign hz.fwd_a  = 2'b00;
    assign hz.fwd_b  = 2'b00;

    wire unused_nofwd = ^sb_wb;
`endif

    // Redirect beats any dependency; reset masks every control
    assign hz.flush = hz.m_pcsrc & ~clr;
    assign hz.stall = hz.id_valid & stall_raw & ~hz.m_pcsrc & ~clr;
    assign issue    = hz.id_valid & ~hz.stall & ~hz.flush;

    always_ff @(negedge clk) begin
        if (clr) begin
            sb_ex       <= '0;
            sb_m        <= '0;
            sb_wb       <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            sb_wb <= sb_m;
            sb_m  <= hz.flush ? '0 : sb_ex;
            sb_ex <= issue ? {hz.id_regwr & (hz.id_rd != 5'd0), hz.id_rd, hz.id_load} : '0;
            if (hz.stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
            if (hz.flush && !(&flush_count)) flush_count <= flush_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed bench for hazard_ctrl with an in-flight instruction model
module tb_hazard_ctrl;
    localparam int SAT_W   = 4;
    localparam int SAT_MAX = (1 << SAT_W) - 1;

    logic             clk;
    logic             clr;
    logic [SAT_W-1:0] stall_count;
    logic [SAT_W-1:0] flush_count;

    hazard_ctrl_if hif ();

    hazard_ctrl #(.SAT_W(SAT_W)) dut (
        .clk         (clk),
        .clr         (clr),
        .hz          (hif),
        .stall_count (stall_count),
        .flush_count (flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // flight[k]: what left ID k+1 falling edges ago (0 = now in EX, 1 = M, 2 = WB)
    typedef struct {
        bit       present;
        bit       writes;
        bit [4:0] rd;
        bit       load;
        bit [4:0] rs1, rs2;
        bit       u1, u2;
    } instr_t;

    instr_t flight[3];
    bit     model_live = 0;
    int     m_stalls   = 0;
    int     m_flushes  = 0;

    function automatic bit depends(input int k, input bit used, input bit [4:0] r);
        return used && r != 0 && flight[k].present && flight[k].writes
               && flight[k].rd != 0 && flight[k].rd == r;
    endfunction

    function automatic bit model_stall();
        bit hit_ex, hit_m;
        if (clr || hif.m_pcsrc || !hif.id_valid) return 0;
        hit_ex = depends(0, hif.id_rs1_used, hif.id_rs1) || depends(0, hif.id_rs2_used, hif.id_rs2);
        hit_m  = depends(1, hif.id_rs1_used, hif.id_rs1) || depends(1, hif.id_rs2_used, hif.id_rs2);
`ifdef HAZARD_FWD_EN
        return hit_ex && flight[0].load;
`else
        return hit_ex || hit_m;
`endif
    endfunction

    function automatic int model_fwd(input bit used, input bit [4:0] r);
`ifdef HAZARD_FWD_EN
        if (clr || !flight[0].present) return 0;
        if (depends(1, used, r) && !flight[1].load) return 1;
        if (depends(2, used, r)) return 2;
        return 0;
`else
        return 0;
`endif
    endfunction

    always @(negedge clk) begin
        bit s, f;
        if (clr) begin
            for (int k = 0; k < 3; k++) flight[k] = '{default: 0};
            m_stalls   = 0;
            m_flushes  = 0;
            model_live = 1;
        end else begin
            s = model_stall();
            f = hif.m_pcsrc;
            if (s && m_stalls < SAT_MAX)  m_stalls++;
            if (f && m_flushes < SAT_MAX) m_flushes++;
            flight[2] = flight[1];
            flight[1] = flight[0];
            if (f) flight[1].present = 0;
            if (hif.id_valid && !s && !f)
                flight[0] = '{1, hif.id_regwr, hif.id_rd, hif.id_load,
                              hif.id_rs1, hif.id_rs2, hif.id_rs1_used, hif.id_rs2_used};
            else
                flight[0] = '{default: 0};
        end
    end

    always @(posedge clk) begin
        if (model_live) begin
            chk("cyc_stall", hif.stall, model_stall());
            chk("cyc_flush", hif.flush, clr ? 0 : hif.m_pcsrc);
            chk("cyc_fwd_a", hif.fwd_a, model_fwd(flight[0].u1, flight[0].rs1));
            chk("cyc_fwd_b", hif.fwd_b, model_fwd(flight[0].u2, flight[0].rs2));
            chk("cyc_stall_count", stall_count, m_stalls);
            chk("cyc_flush_count", flush_count, m_flushes);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        hif.id_valid = 0;
        hif.m_pcsrc  = 0;
        repeat (3) tick();
    endtask

    task automatic set_id(input logic [4:0] rd, input logic wr, input logic ld,
                          input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
        hif.id_valid    = 1;
        hif.id_rd       = rd;
        hif.id_regwr    = wr;
        hif.id_load     = ld;
        hif.id_rs1      = r1;
        hif.id_rs1_used = u1;
        hif.id_rs2      = r2;
        hif.id_rs2_used = u2;
    endtask

    // Hold the instruction in ID until it issues; returns the number of stall cycles
    task automatic send(input logic [4:0] rd, input logic wr, input logic ld,
                        input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                        output int stalls);
        bit st;
        set_id(rd, wr, ld, r1, u1, r2, u2);
        stalls = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            st = hif.stall;
            tick();
            if (!st) begin
                hif.id_valid = 0;
                return;
            end
            stalls++;
        end
        chk("send_timeout", stalls, 0);
        hif.id_valid = 0;
    endtask

    task automatic sample_idle(output logic [1:0] fa, output logic [1:0] fb);
        hif.id_valid = 0;
        @(posedge clk);
        #1;
        fa = hif.fwd_a;
        fb = hif.fwd_b;
        tick();
    endtask

    initial begin
        int         n;
        logic [1:0] fa, fb;
        int         sc0, fc0;
        bit         fwd_build;
`ifdef HAZARD_FWD_EN
        fwd_build = 1;
`else
        fwd_build = 0;
`endif
        clr = 1;
        hif.m_pcsrc = 1;
        set_id(5'd9, 1, 0, 5'd5, 1, 5'd0, 0);

        // Reset: redirect and a source present, yet everything is masked
        @(posedge clk); #1;
        chk("rst_stall", hif.stall, 0);
        chk("rst_flush", hif.flush, 0);
        chk("rst_fwd_a", hif.fwd_a, 0);
        chk("rst_fwd_b", hif.fwd_b, 0);
        tick();
        @(posedge clk); #1;
        chk("rst_flush2", hif.flush, 0);
        chk("rst_stall_count", stall_count, 0);
        chk("rst_flush_count", flush_count, 0);
        tick();
        clr = 0;
        drain();

        // RAW: add x5 ; sub x?, x5
        sc0 = stall_count;
        send(5'd5, 1, 0, 5'd1, 1, 5'd2, 1, n);
        chk("raw_producer_stalls", n, 0);
        send(5'd8, 1, 0, 5'd5, 1, 5'd3, 1, n);
        chk("raw_stalls", n, fwd_build ? 0 : 2);
        chk("raw_stall_count", stall_count - sc0, fwd_build ? 0 : 2);
        sample_idle(fa, fb);
        chk("raw_fwd_a", fa, fwd_build ? 2'b01 : 2'b00);
        drain();

        // RAW with one independent instruction between
        send(5'd5, 1, 0, 5'd1, 1, 5'd2, 1, n);
        send(5'd7, 1, 0, 5'd1, 1, 5'd0, 0, n);
        chk("gap_indep_stalls", n, 0);
        send(5'd8, 1, 0, 5'd5, 1, 5'd0, 0, n);
        chk("gap_stalls", n, fwd_build ? 0 : 1);
        sample_idle(fa, fb);
        chk("gap_fwd_a", fa, fwd_build ? 2'b10 : 2'b00);
        drain();

        // Load-use: lw x6 ; add x?, x?, x6
        send(5'd6, 1, 1, 5'd2, 1, 5'd0, 0, n);
        send(5'd9, 1, 0, 5'd3, 1, 5'd6, 1, n);
        chk("ldu_stalls", n, fwd_build ? 1 : 2);
        sample_idle(fa, fb);
        chk("ldu_fwd_b", fb, fwd_build ? 2'b10 : 2'b00);
        chk("ldu_fwd_a", fa, 0);
        drain();

        // Redirect while ID would stall on the EX-stage lw x5
        fc0 = flush_count;
        send(5'd5, 1, 1, 5'd1, 1, 5'd0, 0, n);
        set_id(5'd8, 1, 0, 5'd5, 1, 5'd0, 0);
        hif.m_pcsrc = 1;
        @(posedge clk); #1;
        chk("redir_flush", hif.flush, 1);
        chk("redir_stall", hif.stall, 0);
        tick();
        hif.m_pcsrc = 0;
        send(5'd8, 1, 0, 5'd5, 1, 5'd5, 1, n);
        chk("redir_no_stall", n, 0);
        chk("redir_flush_count", flush_count - fc0, 1);
        drain();

        // Back-to-back redirects count independently
        fc0 = flush_count;
        hif.m_pcsrc = 1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("b2b_flush", hif.flush, 1);
            tick();
        end
        hif.m_pcsrc = 0;
        chk("b2b_flush_count", flush_count - fc0, 2);
        drain();

        // Writes to x0 are never tracked
        send(5'd0, 1, 0, 5'd1, 1, 5'd0, 0, n);
        send(5'd4, 1, 0, 5'd0, 1, 5'd0, 1, n);
        chk("x0_stalls", n, 0);
        drain();

        // Reset in the middle of a stall
        send(5'd5, 1, 1, 5'd1, 1, 5'd0, 0, n);
        set_id(5'd8, 1, 0, 5'd5, 1, 5'd0, 0);
        @(posedge clk); #1;
        chk("mid_stall_before", hif.stall, 1);
        tick();
        clr = 1;
        @(posedge clk); #1;
        chk("mid_stall_clr", hif.stall, 0);
        tick();
        clr = 0;
        send(5'd8, 1, 0, 5'd5, 1, 5'd0, 0, n);
        chk("mid_stall_after", n, 0);
        chk("mid_stall_count", stall_count, 0);
        drain();

        // Saturation of the stall counter
        for (int i = 0; i < 20; i++) begin
            send(5'd6, 1, 1, 5'd2, 1, 5'd0, 0, n);
            send(5'd9, 1, 0, 5'd3, 1, 5'd6, 1, n);
        end
        chk("sat_stall_count", stall_count, SAT_MAX);
        send(5'd6, 1, 1, 5'd2, 1, 5'd0, 0, n);
        send(5'd9, 1, 0, 5'd6, 1, 5'd0, 0, n);
        chk("sat_more_stalls", n, fwd_build ? 1 : 2);
        chk("sat_hold", stall_count, SAT_MAX);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage IF/ID/EX/M/WB core. It keeps a shadow scoreboard of in-flight destination registers and generates the stall and flush controls for the PC and the IF/ID, ID/EX and EX/M pipeline registers. When forwarding is compiled in, it also drives the EX-stage operand-forward selects. It sits beside `pipeline`, reads decode fields from ID and the redirect from M, and drives hold/zero enables into the stage registers.

## Interface
Parameters:
- `SAT_W`, 16: width of the saturating performance counters.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the falling edge, same edge as the stage registers.
- `clr`  in  1  reset, synchronous, active-high.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs1`, `id_rs2`  in  5 each  ID source register addresses.
- `id_rs1_used`, `id_rs2_used`  in  1 each  the source is actually read.
- `id_rd`  in  5  ID destination register.
- `id_regwr`  in  1  ID instruction writes `id_rd`.
- `id_load`  in  1  ID instruction is a load (MemtoReg).
- `m_pcsrc`  in  1  M stage redirects the PC (taken branch or jump).
- `stall`  out  1  hold PC and IF/ID; load a bubble into ID/EX.
- `flush`  out  1  zero IF/ID, ID/EX and EX/M.
- `fwd_a`, `fwd_b`  out  2 each  EX operand select: 00 regfile, 01 EX/M aluresult, 10 WB busW.
- `stall_count`, `flush_count`  out  SAT_W each  saturating event counters.

## Operation
- Shadow slots `sb_ex`, `sb_m`, `sb_wb` each hold {valid, rd, load}. `sb_ex` also holds the registered `rs1`, `rs2` and used bits of the instruction in EX.
- An ID instruction "issues" when `id_valid & ~stall & ~flush`.
- Per-edge update:
  - `sb_wb <= sb_m`.
  - `sb_m <= flush ? invalid : sb_ex`.
  - `sb_ex <= issue ? {id_regwr & (id_rd != 0), id_rd, id_load, srcs} : invalid`.
- Match condition: a source matches a slot when the source is used, its address is nonzero, the slot is valid, and the slot's rd equals the source address.
- Register-file writes complete mid-cycle in WB, so `sb_wb` never causes a stall.
- Without forwarding: `stall = id_valid & (match(sb_ex) | match(sb_m))`. The maximum stall is 2 consecutive cycles.
- With forwarding: `stall = id_valid & match(sb_ex) & sb_ex.load` (load-use, exactly 1 cycle).
- `fwd_a` is computed from the EX sources: 01 if it matches `sb_m` and `sb_m` is not a load, else 10 if it matches `sb_wb`, else 00. `sb_m` has priority over `sb_wb`. `fwd_b` is computed the same way.
- `flush = m_pcsrc`.
- Flush overrides stall: while `flush` = 1, `stall` is forced to 0 and nothing issues. Wrong-path entries (EX slot and the ID instruction) are dropped, so they never create later stalls or forwards.
- Counters:
  - `stall_count` increments each cycle `stall` = 1.
  - `flush_count` increments each cycle `flush` = 1.
  - Both saturate at all-ones and do not wrap.

## Timing
- `stall`, `flush`, `fwd_*` are combinational from the inputs and the slots, valid within the same cycle.
- Stall and flush take effect at the next falling edge.
- `clr` = 1 at an edge:
  - All slots invalid.
  - Counters reset to 0.
- While `clr` is high, `stall` = 0, `flush` = 0, `fwd_a` = `fwd_b` = 00 regardless of inputs.
- Reset asserted mid-stall: the stall ends immediately, and the pending dependency is discarded.
- Back-to-back redirects: each cycle with `m_pcsrc` = 1 flushes independently.
- A redirect arriving while a stall is in progress terminates the stall.
- Writes to x0 never enter a slot as valid.

## Configuration
- `HAZARD_FWD_EN` defined: the forwarding network is compiled in, with load-use-only stalls and live `fwd_a`/`fwd_b`.
- `HAZARD_FWD_EN` undefined:
  - Full interlock, stalling on any EX or M match.
  - `fwd_a` and `fwd_b` are tied to 00.
  - The EX source registers in `sb_ex` are not built.

## Test plan
- **Reset:** hold `clr` 2 cycles with `m_pcsrc` = 1 and a matching ID source → `stall` = 0, `flush` = 0, `fwd` = 00, counters 0.
- **No FWD, RAW:** `add x5` issued, then ID reads x5 as rs1 → `stall` = 1 for exactly 2 cycles, then issue; `stall_count` = 2.
- **FWD, RAW:**
  - `add x5` then `sub` using x5 → no stall, `fwd_a` = 01 during the sub's EX cycle.
  - With one independent instruction between them → `fwd_a` = 10.
- **FWD, load-use:** `lw x6` then `add` using x6 as rs2 → `stall` = 1 for 1 cycle, then `fwd_b` = 10 in EX.
- **Redirect vs stall:** `m_pcsrc` = 1 while ID has a stall-causing dependency → `flush` = 1, `stall` = 0. The next instruction, reading the flushed instruction's rd, does not stall. `flush_count` = 1.
- **x0 and saturation:** `addi x0` followed by a read of x0 → no stall. Force `stall_count` to all-ones, then stall again → the count stays at all-ones.
